wbrrarbiter: RTL
================

# wbrrarbiter

Two-master, single-slave pipelined Wishbone arbiter with round-robin grant and a bus-timeout watchdog. It shares one Wishbone slave (the `memdev` block RAM) between the `wbdeppsimple` DEPP bridge on port A and a second master on port B, such as the `rpi2B_io` parallel path or a DWT engine. Grant is held for the owner's whole `cyc` and handed over only when `cyc` drops. A hung slave is aborted with an error after a programmable number of idle cycles.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `LGTIMEOUT`, 10, log2 of watchdog limit; limit is 2^LGTIMEOUT cycles
- `LGOUT`, 4, log2 of maximum outstanding requests tracked
- `i_clk`  in  1  system clock; everything is on the rising edge
- `i_reset_n`  in  1  reset, synchronous, active-low
- `i_a_cyc`, `i_a_stb`, `i_a_we`  in  1  master A bus-cycle, strobe and write-enable
- `i_a_addr`  in  AW  master A address
- `i_a_data`  in  DW  master A write data
- `o_a_ack`, `o_a_stall`, `o_a_err`  out  1  master A acknowledge, stall and error
- `o_a_data`  out  DW  master A read data
- `i_b_*` / `o_b_*`  as port A  master B
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1  slave-side bus-cycle, strobe and write-enable
- `o_wb_addr`  out  AW  slave address
- `o_wb_data`  out  DW  slave write data
- `i_wb_ack`, `i_wb_stall`, `i_wb_err`  in  1  slave acknowledge, stall and error
- `i_wb_data`  in  DW  slave read data

## Operation
- State machine has four states: IDLE, OWN_A, OWN_B, ABORT. Only the state register and `last_b` are registered; all bus routing is combinational from them.
- **IDLE**
  - `i_a_cyc` alone → OWN_A.
  - `i_b_cyc` alone → OWN_B.
  - Both → the master not granted last wins.
  - `last_b` resets to 1, so A wins the first tie.
- **OWN_x**
  - `o_wb_cyc = i_x_cyc`, `o_wb_stb = i_x_stb`; `we`, `addr` and `data` come from x.
  - `o_x_ack = i_wb_ack`, `o_x_err = i_wb_err`, `o_x_stall = i_wb_stall`.
  - `o_x_data = i_wb_data`, routed to both masters at all times.
  - `i_x_cyc` = 0 → IDLE; `last_b` is set to (x == B).
- **Non-owner y** (in any state):
  - `o_y_stall = i_y_stb`
  - `o_y_ack = 0`, `o_y_err = 0`
- **Outstanding counter** (LGOUT+1 bits)
  - +1 on accepted strobe (`o_wb_stb & ~i_wb_stall`); −1 on `i_wb_ack` or `i_wb_err`.
  - Simultaneous +1 and −1 → unchanged.
  - Cleared on entering IDLE or ABORT.
  - At 2^LGOUT outstanding, the owner is force-stalled.
- **Watchdog counter** (LGTIMEOUT bits)
  - Cleared on any ack, err, accepted strobe, or state change.
  - Increments while in OWN_x with outstanding > 0 or with stb stalled.
  - On reaching all-ones: pulse `o_x_err` for exactly 1 cycle, then go to ABORT.
- **ABORT**
  - `o_wb_cyc` = 0, `o_wb_stb` = 0.
  - The former owner sees stall while its stb is high; ack and err are 0.
  - Late slave acks are discarded.
  - Former owner's `cyc` = 0 → IDLE, with `last_b` updated as for a normal release.
- **Slave error:** `i_wb_err` passes to the owner unchanged. The arbiter waits for the master to drop `cyc`; it does not enter ABORT.
- **Owner drops `cyc` with requests outstanding:** `o_wb_cyc` falls in the same cycle, and any acks still in flight are discarded.

## Timing
- **Reset values** (state IDLE, counters 0):
  - `o_wb_cyc`, `o_wb_stb`, `o_wb_we` = 0
  - all ack and err outputs = 0
  - stall outputs = the corresponding `i_x_stb`
  - `o_wb_addr` and `o_wb_data` = 0
- **Reset mid-transaction:** all of the above take effect at the next edge, and the outstanding transaction is dropped.
- **Grant latency:** 1 cycle. The request is seen in IDLE (requester stalled that cycle). From the next cycle, the owner's signals pass through with 0 latency.
- **Handover:** owner drops `cyc` at cycle n → state is IDLE at n+1 → waiting master is OWN at n+2. There is a minimum 1-cycle IDLE gap with `o_wb_cyc` = 0.
- **Watchdog:** `o_x_err` asserts 2^LGTIMEOUT−1 cycles after the last activity. `o_wb_cyc` is low from the following cycle.

## Structure
- A shared package `wbarb_pkg` holds:
  - the state encoding (IDLE=0, OWN_A=1, OWN_B=2, ABORT=3);
  - the default width constants.
- Sub-module `wbarb_watchdog` contains the timeout counter plus the outstanding counter. Its inputs are `stb_accepted`, `resp` and `clear`; its output is `expired`.

## Test plan
- **A-only write/read:** A writes 0xDEADBEEF to address 0x10 through `memdev`, then reads it back. Required:
  - A stalled in the first cycle, granted in the second;
  - read returns 0xDEADBEEF;
  - `o_b_ack` stays 0 throughout.
- **Tie after reset:** A and B raise `cyc`/`stb` in the same cycle. Required:
  - A is granted and B is stalled;
  - after A releases, IDLE for 1 cycle, then OWN_B;
  - on the next tie, A wins.
- **Contention during ownership:** B requests while A is mid-burst of 4 pipelined reads. Required:
  - B stays stalled and receives no ack;
  - A receives 4 acks;
  - B is granted 2 cycles after A drops `cyc`.
- **Timeout** (LGTIMEOUT=4, slave never acks):
  - one accepted strobe → `o_a_err` pulses after 15 cycles;
  - `o_wb_cyc` = 0 the next cycle;
  - state returns to IDLE only after A drops `cyc`.
- **Reset mid-burst:** assert `i_reset_n`=0 for 1 cycle during an OWN_B burst. Required:
  - `o_wb_cyc` = 0 and state IDLE at the next edge;
  - a subsequent tie grants A.
- **Slave error passthrough:** force `i_wb_err` on B's read. Required:
  - `o_b_err` = 1 in the same cycle;
  - no ABORT state is entered;
  - normal handover follows when B drops `cyc`.

Source files
------------

// File: rtl/wbarb_pkg.sv
// Shared definitions for the two-master round-robin Wishbone arbiter:
// the arbiter state encoding and the default bus and counter widths.
package wbarb_pkg;

    localparam int unsigned AW_DEF        = 32;
    localparam int unsigned DW_DEF        = 32;
    localparam int unsigned LGTIMEOUT_DEF = 10;
    localparam int unsigned LGOUT_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wbarb_watchdog.sv
// Bus watchdog for the arbiter: tracks requests outstanding at the slave and
// counts idle cycles while the owner waits on the slave.
//   clk, reset_n  : clock, synchronous active-low reset
//   clear         : no owner holding cyc; zero both counters
//   stb_accepted  : strobe accepted by the slave this cycle
//   stb_pending   : owner strobe held off this cycle (stalled)
//   resp          : slave ack or err this cycle
//   expired       : the idle counter steps onto all-ones this cycle
//   full          : 2^LGOUT requests outstanding, owner must be stalled
module wbarb_watchdog
    import wbarb_pkg::*;
#(
    parameter int unsigned LGTIMEOUT = LGTIMEOUT_DEF,
    parameter int unsigned LGOUT     = LGOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic stb_accepted,
    input  logic stb_pending,
    input  logic resp,
    output logic expired,
    output logic full
);

    localparam int unsigned OW = LGOUT + 1;
    localparam logic [OW-1:0] OUT_MAX = OW'(2 ** LGOUT);
    localparam logic [LGTIMEOUT-1:0] CNT_LAST = LGTIMEOUT'((2 ** LGTIMEOUT) - 2);

    logic [OW-1:0]        outstanding;
    logic [LGTIMEOUT-1:0] count;
    logic                 activity;
    logic                 running;

    assign activity = stb_accepted | resp;
    assign running  = (outstanding != '0) | stb_pending;
    assign full     = (outstanding == OUT_MAX);
    // Fires on the cycle the counter would reach all-ones, so the error
    // lands 2^LGTIMEOUT-1 cycles after the last bus activity.
    assign expired  = ~clear & ~activity & running & (count == CNT_LAST);

    // Outstanding request count; a response with nothing outstanding is a
    // stale ack from an abandoned cycle and is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (clear) begin
            outstanding <= '0;
        end else if (stb_accepted && !resp) begin
            outstanding <= outstanding + OW'(1);
        end else if (!stb_accepted && resp && (outstanding != '0)) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    // Idle-cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || activity) begin
            count <= '0;
        end else if (running) begin
            count <= count + LGTIMEOUT'(1);
        end
    end

endmodule

// File: rtl/wbrrarbiter.sv
// Two-master, single-slave pipelined Wishbone arbiter with round-robin grant
// held for the owner's whole cyc, and a watchdog that aborts a hung slave.
//   i_clk, i_reset_n           : clock, synchronous active-low reset
//   i_a_* / o_a_*              : master A (cyc, stb, we, addr, data / ack, stall, err, data)
//   i_b_* / o_b_*              : master B, same as A
//   o_wb_* / i_wb_*            : shared slave port
// Only the state and last-grant registers are clocked; bus routing is
// combinational from them.
module wbrrarbiter
    import wbarb_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned LGTIMEOUT = LGTIMEOUT_DEF,
    parameter int unsigned LGOUT     = LGOUT_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    output logic [DW-1:0] o_a_data,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [DW-1:0] o_b_data,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data
);

    arb_state_t state, state_d;
    logic       last_b, last_b_d;

    logic own_a, own_b, own_cyc, own_stb, wb_stb;
    logic stb_accepted, stb_pending, resp, wd_clear;
    logic expired, full;

    // Owner-side strobe path, shared by the routing and the watchdog
    assign own_a        = (state == ST_OWN_A);
    assign own_b        = (state == ST_OWN_B);
    assign own_cyc      = (own_a & i_a_cyc) | (own_b & i_b_cyc);
    assign own_stb      = (own_a & i_a_cyc & i_a_stb) | (own_b & i_b_cyc & i_b_stb);
    assign wb_stb       = own_stb & ~full;
    assign stb_accepted = wb_stb & ~i_wb_stall;
    assign stb_pending  = own_stb & ~stb_accepted;
    assign resp         = i_wb_ack | i_wb_err;
    assign wd_clear     = ~own_cyc;

    // Read data goes to both masters; only the owner sees the ack
    assign o_a_data = i_wb_data;
    assign o_b_data = i_wb_data;

    wbarb_watchdog #(
        .LGTIMEOUT (LGTIMEOUT),
        .LGOUT     (LGOUT)
    ) u_watchdog (
        .clk          (i_clk),
        .reset_n      (i_reset_n),
        .clear        (wd_clear),
        .stb_accepted (stb_accepted),
        .stb_pending  (stb_pending),
        .resp         (resp),
        .expired      (expired),
        .full         (full)
    );

    // State and last-grant registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            last_b <= 1'b1;
        end else begin
            state  <= state_d;
            last_b <= last_b_d;
        end
    end

    // Next state and bus routing. In ABORT, last_b already names the
    // former owner, so releasing from ABORT leaves it unchanged.
    always_comb begin
        state_d   = state;
        last_b_d  = last_b;
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_a_stall = i_a_stb;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        o_b_stall = i_b_stb;

        unique case (state)
            ST_IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    state_d = last_b ? ST_OWN_A : ST_OWN_B;
                end else if (i_a_cyc) begin
                    state_d = ST_OWN_A;
                end else if (i_b_cyc) begin
                    state_d = ST_OWN_B;
                end
            end

            ST_OWN_A: begin
                o_wb_cyc  = i_a_cyc;
                o_wb_stb  = wb_stb;
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_a_ack   = i_a_cyc & i_wb_ack;
                o_a_err   = i_a_cyc & (i_wb_err | expired);
                o_a_stall = i_wb_stall | full;
                if (!i_a_cyc) begin
                    state_d  = ST_IDLE;
                    last_b_d = 1'b0;
                end else if (expired) begin
                    state_d  = ST_ABORT;
                    last_b_d = 1'b0;
                end
            end

            ST_OWN_B: begin
                o_wb_cyc  = i_b_cyc;
                o_wb_stb  = wb_stb;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_b_ack   = i_b_cyc & i_wb_ack;
                o_b_err   = i_b_cyc & (i_wb_err | expired);
                o_b_stall = i_wb_stall | full;
                if (!i_b_cyc) begin
                    state_d  = ST_IDLE;
                    last_b_d = 1'b1;
                end else if (expired) begin
                    state_d  = ST_ABORT;
                    last_b_d = 1'b1;
                end
            end

            ST_ABORT: begin
                if (last_b ? !i_b_cyc : !i_a_cyc) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
